boa_stage_mem: RTL and testbench
================================

Name: boa_stage_mem

Overview:
- Boa³² pipeline stage MEM, directly downstream of EX.
- Registers the EX/MEM barrier and performs LOAD/STORE accesses over a single-master data bus with a ready handshake.
- Generates byte enables, sign/zero-extends load data, and raises misalignment and access-fault traps.
- Passes non-memory results through to WB, and holds completed load data across downstream stalls.

Parameters:
- none (fixed 32-bit datapath)

Ports:
clk  in  1  CPU clock
rst_n  in  1  synchronous reset, active-low
clear  in  1  invalidate current instruction; suppress traps and any not-yet-issued bus access
d_valid  in  1  EX/MEM: result valid
d_pc  in  31  EX/MEM: instruction PC [31:1]
d_insn  in  32  EX/MEM: instruction word
d_use_rd  in  1  EX/MEM: writes RD
d_rs1_val  in  32  EX/MEM: ALU result / memory address
d_rs2_val  in  32  EX/MEM: store data
d_trap  in  1  EX/MEM: trap raised
d_cause  in  4  EX/MEM: trap cause
q_valid  out  1  MEM/WB: result valid
q_pc  out  31  MEM/WB: PC
q_insn  out  32  MEM/WB: instruction word
q_use_rd  out  1  MEM/WB: writes RD
q_rs1_val  out  32  MEM/WB: final RD value
q_trap  out  1  MEM/WB: trap raised
q_cause  out  4  MEM/WB: trap cause
bus_re  out  1  read request
bus_we  out  4  byte write enables; nonzero = write request
bus_addr  out  30  word address [31:2]
bus_wdata  out  32  lane-aligned write data
bus_rdata  in  32  read data, valid when bus_ready
bus_ready  in  1  access complete this cycle
bus_fault  in  1  access error; qualified by bus_ready
fw_stall_mem  in  1  hold MEM barrier register
fw_busy_mem  out  1  MEM waiting on bus; upstream must stall
fw_rd  out  1  q_rs1_val is final and forwardable

Behaviour:
- Barrier register: on reset r_valid=0, r_trap=0, state=IDLE, others don't-care. Loads when !fw_stall_mem && !fw_busy_mem.
- Classification: mem = r_valid && !r_trap && opcode LOAD/STORE. Size = insn[13:12]: 00 byte, 01 half, 10 word. Unsigned when insn[14].
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- Without the optional feature, a misaligned access issues no bus access; q_trap=1, cause 4 (load) or 6 (store), in the same cycle.
- Stores: byte lanes replicate rs2. bus_we is 0001<<a / 0011<<a / 1111.
- Loads: select lane by addr[1:0], then sign- or zero-extend.
- FSM states: IDLE, WAIT, HOLD (plus SPLIT with the feature).
  - IDLE + mem + !misaligned + !clear: request driven combinationally from r_ registers.
    - If bus_ready is high the same cycle, the result is valid that cycle (0-wait). Go to HOLD if fw_stall_mem, else stay IDLE.
    - If bus_ready is low: go to WAIT; fw_busy_mem=1.
  - WAIT: request held stable until bus_ready. Then latch extended data into r_ldata and go to HOLD if fw_stall_mem, else IDLE.
  - HOLD: bus idle; q_rs1_val=r_ldata. Exit to IDLE when !fw_stall_mem.
- The request must not re-issue while in HOLD, so each instruction gets exactly one bus transaction per access.
- bus_fault with bus_ready: q_trap=1, cause 5 (load) or 7 (store).
- fw_busy_mem=1 whenever a request is outstanding without bus_ready, in WAIT or SPLIT.
- clear:
  - in IDLE: the request is suppressed.
  - in WAIT: the request stays held until bus_ready, then the result is discarded and the FSM goes to IDLE.
  - A bus request is never dropped mid-transaction.
- Output gating: q_valid = r_valid && !clear && !fw_busy_mem; q_trap = !clear && (r_trap || new trap).
- fw_rd:
  - non-mem with use_rd: r_valid && r_use_rd.
  - LOAD: 1 only when data is available (ready cycle or HOLD).
  - STORE: 0.
- Non-mem instructions pass d_rs1_val through unchanged; the bus stays idle.
- Reset mid-access (rst_n=0 in WAIT): state=IDLE and requests deasserted next cycle; the outstanding transaction is abandoned.

Optional Feature:
- Macro: BOA_MEM_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses are split into two aligned bus accesses: word at addr, then word at addr+4, via state SPLIT.
  - First-access read data is latched into r_lo.
  - Loads are assembled from the shifted concatenation {second, first}. Stores use lane masks covering the low and high portions.
  - No misaligned trap; a fault on either half gives cause 5/7.
  - Wrap at 0xFFFF_FFFC+4 goes to word 0.
- Undefined: misaligned traps as above; SPLIT state and r_lo are absent.

Decomposition:
- boa_defines.svh additions:
  - size constants: RV_MEM_BYTE=2'b00, RV_MEM_HALF=2'b01, RV_MEM_WORD=2'b10.
  - trap cause constants: 4/5/6/7.
  - FSM state enum typedef.
- One sub-module: boa_mem_align, purely combinational lane logic. Computes byte enables, write data replication, load extraction/extension and the misalign flag.

Test Plan:
- LB from 0x1003, bus_rdata=0x80FF_FF11, 0-wait -> q_rs1_val=0xFFFF_FF80, fw_rd=1 same cycle, bus_re high for one cycle.
- SH rs2=0x1234ABCD to 0x2002, bus_ready after 3 cycles -> bus_we=1100, bus_wdata[31:16]=0xABCD, fw_busy_mem=1 for 3 cycles, then q_valid=1.
- LW from 0x4000, data 0xDEADBEEF; fw_stall_mem held 2 cycles after ready -> HOLD, q_rs1_val stays 0xDEADBEEF, exactly one bus_re pulse.
- LW from 0x4002 without feature -> no bus access, q_trap=1, q_cause=4. With feature: two reads (0x4000→0x33221100, 0x4004→0x77665544) -> 0x55443322.
- SW with bus_fault=1 on ready -> q_trap=1, q_cause=7. Then clear asserted during a WAIT load -> request held to bus_ready, q_valid=0.
- ADD result 0x55 passes with use_rd=1 -> q_rs1_val=0x55, fw_rd=1, bus idle. rst_n=0 during WAIT -> bus_re=0 next cycle, q_valid=0.

Source files
------------

// File: rtl/boa_stage_mem_pkg.sv
// Shared constants for the Boa32 MEM stage: access sizes, trap causes,
// opcodes, FSM state encodings and the access-size lane mask helper.
// Optional build macro: BOA_MEM_MISALIGN_SPLIT_EN (adds the SPLIT state).
package boa_stage_mem_pkg;

  localparam logic [1:0] RV_MEM_BYTE = 2'b00;
  localparam logic [1:0] RV_MEM_HALF = 2'b01;
  localparam logic [1:0] RV_MEM_WORD = 2'b10;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t ST_IDLE  = 2'd0;
  localparam mem_state_t ST_WAIT  = 2'd1;
  localparam mem_state_t ST_HOLD  = 2'd2;
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
  localparam mem_state_t ST_SPLIT = 2'd3;
`endif

  // Byte-lane mask of an access before it is shifted to its address offset.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      RV_MEM_BYTE: return 4'b0001;
      RV_MEM_HALF: return 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/boa_mem_align.sv
// Combinational lane logic for the MEM stage: byte enables, store data
// placement, load lane extraction with sign/zero extension, misalign flag.
// With BOA_MEM_MISALIGN_SPLIT_EN it also produces the second-word lanes and
// assembles loads from a {second, first} word pair.
module boa_mem_align
  import boa_stage_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_val,
  input  logic [31:0] rdata_lo,
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_hi,
`endif
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic [31:0] lane;
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
  logic [7:0]  be8;
  logic [63:0] wide_wdata;
`endif

  // Lane placement for stores and extraction/extension for loads.
  always_comb begin
    misaligned = ((size == RV_MEM_HALF) && offset[0]) ||
                 (size[1] && (offset != 2'b00));

    case (size)
      RV_MEM_BYTE: wdata = {4{store_val[7:0]}};
      RV_MEM_HALF: wdata = {2{store_val[15:0]}};
      default:     wdata = store_val;
    endcase

`ifdef BOA_MEM_MISALIGN_SPLIT_EN
    be8        = {4'b0000, size_mask(size)} << offset;
    be         = be8[3:0];
    be_hi      = be8[7:4];
    wide_wdata = {32'h0, store_val} << {offset, 3'b000};
    wdata_hi   = wide_wdata[63:32];
    if (misaligned) wdata = wide_wdata[31:0];
    lane       = 32'({rdata_hi, rdata_lo} >> {offset, 3'b000});
`else
    be   = size_mask(size) << offset;
    lane = rdata_lo >> {offset, 3'b000};
`endif

    case (size)
      RV_MEM_BYTE: load_val = is_unsigned ? {24'h0, lane[7:0]}
                                          : {{24{lane[7]}}, lane[7:0]};
      RV_MEM_HALF: load_val = is_unsigned ? {16'h0, lane[15:0]}
                                          : {{16{lane[15]}}, lane[15:0]};
      default:     load_val = lane;
    endcase
  end

endmodule

// File: rtl/boa_stage_mem.sv
// Boa32 MEM pipeline stage: EX/MEM barrier register, single-master data bus
// access with ready handshake, load extension, misalign/fault traps, and a
// HOLD state that keeps completed load data across downstream stalls.
// Optional build macro: BOA_MEM_MISALIGN_SPLIT_EN splits misaligned accesses
// into two aligned word accesses instead of trapping.
module boa_stage_mem
  import boa_stage_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        d_valid,
  input  logic [30:0] d_pc,
  input  logic [31:0] d_insn,
  input  logic        d_use_rd,
  input  logic [31:0] d_rs1_val,
  input  logic [31:0] d_rs2_val,
  input  logic        d_trap,
  input  logic [3:0]  d_cause,
  output logic        q_valid,
  output logic [30:0] q_pc,
  output logic [31:0] q_insn,
  output logic        q_use_rd,
  output logic [31:0] q_rs1_val,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  output logic        bus_re,
  output logic [3:0]  bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_fault,
  input  logic        fw_stall_mem,
  output logic        fw_busy_mem,
  output logic        fw_rd
);

  logic        r_valid, r_use_rd, r_trap;
  logic [30:0] r_pc;
  logic [31:0] r_insn, r_rs1_val, r_rs2_val;
  logic [3:0]  r_cause;
  mem_state_t  state, state_nx;
  logic [31:0] r_ldata;
  logic        r_lfault, r_flush;

  logic        load_barrier, is_load, is_store, is_mem, kill;
  logic        req_idle, req_active, done_final, fault_now;
  logic        mis_trap, new_trap;
  logic [3:0]  new_cause;
  logic [3:0]  be;
  logic [31:0] wdata, load_val;
  logic        misaligned;

`ifdef BOA_MEM_MISALIGN_SPLIT_EN
  logic [31:0] r_lo;
  logic        r_fault1, second, first_done;
  logic [3:0]  be_hi;
  logic [31:0] wdata_hi;
`endif

  assign load_barrier = !fw_stall_mem && !fw_busy_mem;
  assign is_load  = r_valid && !r_trap && (r_insn[6:0] == OPC_LOAD);
  assign is_store = r_valid && !r_trap && (r_insn[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign kill     = clear || r_flush;

  boa_mem_align u_align (
    .offset      (r_rs1_val[1:0]),
    .size        (r_insn[13:12]),
    .is_unsigned (r_insn[14]),
    .store_val   (r_rs2_val),
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
    .rdata_lo    (second ? r_lo : bus_rdata),
    .rdata_hi    (bus_rdata),
    .be_hi       (be_hi),
    .wdata_hi    (wdata_hi),
`else
    .rdata_lo    (bus_rdata),
`endif
    .be          (be),
    .wdata       (wdata),
    .load_val    (load_val),
    .misaligned  (misaligned)
  );

`ifdef BOA_MEM_MISALIGN_SPLIT_EN
  assign second     = (state == ST_SPLIT);
  assign req_idle   = (state == ST_IDLE) && is_mem && !kill;
  assign req_active = req_idle || (state == ST_WAIT) || second;
  assign first_done = req_active && bus_ready && misaligned && !second;
  assign done_final = req_active && bus_ready && !(misaligned && !second);
  assign fault_now  = done_final && (bus_fault || (second && r_fault1));
  assign mis_trap   = 1'b0;
  assign bus_addr   = second ? (r_rs1_val[31:2] + 30'd1) : r_rs1_val[31:2];
  assign bus_we     = (req_active && is_store) ? (second ? be_hi : be) : 4'b0000;
  assign bus_wdata  = second ? wdata_hi : wdata;
`else
  assign req_idle   = (state == ST_IDLE) && is_mem && !misaligned && !kill;
  assign req_active = req_idle || (state == ST_WAIT);
  assign done_final = req_active && bus_ready;
  assign fault_now  = done_final && bus_fault;
  assign mis_trap   = is_mem && misaligned;
  assign bus_addr   = r_rs1_val[31:2];
  assign bus_we     = (req_active && is_store) ? be : 4'b0000;
  assign bus_wdata  = wdata;
`endif

  assign bus_re      = req_active && is_load;
  assign fw_busy_mem = req_active && !done_final;

  assign new_trap  = mis_trap || fault_now || ((state == ST_HOLD) && r_lfault);
  assign new_cause = mis_trap ? (is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN)
                              : (is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT);

  assign q_valid   = r_valid && !kill && !fw_busy_mem;
  assign q_pc      = r_pc;
  assign q_insn    = r_insn;
  assign q_use_rd  = r_use_rd;
  assign q_trap    = !kill && (r_trap || new_trap);
  assign q_cause   = (!r_trap && new_trap) ? new_cause : r_cause;
  assign q_rs1_val = (is_load && (state == ST_HOLD)) ? r_ldata :
                     (is_load && done_final)         ? load_val : r_rs1_val;
  assign fw_rd     = r_valid && r_use_rd && !is_store &&
                     (!is_load || done_final || (state == ST_HOLD));

  // Control half of the EX/MEM barrier; only valid/trap need a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_trap  <= 1'b0;
    end else if (load_barrier) begin
      r_valid <= d_valid;
      r_trap  <= d_trap;
    end
  end

  // Data half of the EX/MEM barrier, advancing with the control half.
  always_ff @(posedge clk) begin
    if (load_barrier) begin
      r_pc      <= d_pc;
      r_insn    <= d_insn;
      r_use_rd  <= d_use_rd;
      r_rs1_val <= d_rs1_val;
      r_rs2_val <= d_rs2_val;
      r_cause   <= d_cause;
    end
  end

  // Next-state logic: one bus transaction per instruction, then IDLE or HOLD.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req_idle) begin
          if (!bus_ready)      state_nx = ST_WAIT;
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
          else if (misaligned) state_nx = ST_SPLIT;
`endif
          else if (fw_stall_mem) state_nx = ST_HOLD;
        end
      end
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
      ST_SPLIT: begin
        if (bus_ready) state_nx = (kill || !fw_stall_mem) ? ST_IDLE : ST_HOLD;
      end
`endif
      ST_WAIT: begin
        if (bus_ready) begin
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
          if (misaligned) state_nx = ST_SPLIT;
          else
`endif
          state_nx = (kill || !fw_stall_mem) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!fw_stall_mem) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register plus a sticky kill that lives until the barrier advances,
  // so a cleared instruction never re-issues while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      r_flush <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_barrier) r_flush <= 1'b0;
      else if (clear)   r_flush <= 1'b1;
    end
  end

  // Capture completed load data and fault status for HOLD and split assembly.
  always_ff @(posedge clk) begin
    if (done_final) begin
      r_ldata  <= load_val;
      r_lfault <= fault_now;
    end
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
    if (first_done) begin
      r_lo     <= bus_rdata;
      r_fault1 <= bus_fault;
    end
`endif
  end

endmodule

// File: tb/tb_boa_stage_mem.sv
// Directed self-checking bench for boa_stage_mem. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values.
module tb_boa_stage_mem;

  localparam logic [31:0] INSN_LB  = 32'h0000_0083;
  localparam logic [31:0] INSN_LH  = 32'h0000_1083;
  localparam logic [31:0] INSN_LW  = 32'h0000_2083;
  localparam logic [31:0] INSN_LBU = 32'h0000_4083;
  localparam logic [31:0] INSN_SH  = 32'h0000_1023;
  localparam logic [31:0] INSN_SW  = 32'h0000_2023;
  localparam logic [31:0] INSN_ADD = 32'h0000_00B3;

  logic        clk = 1'b0;
  logic        rst_n, clear, d_valid, d_use_rd, d_trap;
  logic [30:0] d_pc;
  logic [31:0] d_insn, d_rs1_val, d_rs2_val;
  logic [3:0]  d_cause;
  logic        q_valid, q_use_rd, q_trap;
  logic [30:0] q_pc;
  logic [31:0] q_insn, q_rs1_val;
  logic [3:0]  q_cause;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready, bus_fault, fw_stall_mem, fw_busy_mem, fw_rd;

  int total = 0;
  int bad   = 0;

  boa_stage_mem dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_use_rd(d_use_rd),
    .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_trap(d_trap), .d_cause(d_cause),
    .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_use_rd(q_use_rd),
    .q_rs1_val(q_rs1_val), .q_trap(q_trap), .q_cause(q_cause),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_fault(bus_fault),
    .fw_stall_mem(fw_stall_mem), .fw_busy_mem(fw_busy_mem), .fw_rd(fw_rd)
  );

  always #5 clk = ~clk;

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the EX/MEM inputs for a single edge.
  task automatic issue(input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic use_rd);
    d_valid = 1'b1; d_insn = insn; d_rs1_val = a; d_rs2_val = b;
    d_use_rd = use_rd; d_trap = 1'b0; d_cause = 4'd0; d_pc = 31'h0000_0800;
    tick();
    d_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; d_valid = 1'b0; d_use_rd = 1'b0; d_trap = 1'b0;
    d_pc = '0; d_insn = '0; d_rs1_val = '0; d_rs2_val = '0; d_cause = '0;
    bus_rdata = '0; bus_ready = 1'b0; bus_fault = 1'b0; fw_stall_mem = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++; if (q_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_q_valid: got %0h expected 0", q_valid); end
    total++; if (q_trap !== 1'b0) begin bad++; $display("[TB] FAIL reset_q_trap: got %0h expected 0", q_trap); end
    total++; if (bus_re !== 1'b0 || bus_we !== 4'b0000) begin bad++; $display("[TB] FAIL reset_bus: got re=%0h we=%0h expected 0/0", bus_re, bus_we); end
    total++; if (fw_busy_mem !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0h expected 0", fw_busy_mem); end
  endtask

  task automatic test_load_zero_wait();
    bus_rdata = 32'h80FF_FF11; bus_ready = 1'b1;
    issue(INSN_LB, 32'h0000_1003, 32'h0, 1'b1);
    total++; if (bus_re !== 1'b1) begin bad++; $display("[TB] FAIL lb_re: got %0h expected 1", bus_re); end
    total++; if (bus_addr !== 30'h400) begin bad++; $display("[TB] FAIL lb_addr: got %0h expected 400", bus_addr); end
    total++; if (q_rs1_val !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_data: got %0h expected ffffff80", q_rs1_val); end
    total++; if (fw_rd !== 1'b1 || q_valid !== 1'b1) begin bad++; $display("[TB] FAIL lb_fwrd_valid: got %0h/%0h expected 1/1", fw_rd, q_valid); end
    tick();
    total++; if (bus_re !== 1'b0) begin bad++; $display("[TB] FAIL lb_re_pulse: got %0h expected 0", bus_re); end
    issue(INSN_LBU, 32'h0000_1001, 32'h0, 1'b1);
    total++; if (q_rs1_val !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL lbu_data: got %0h expected ff", q_rs1_val); end
    tick();
    issue(INSN_LH, 32'h0000_1002, 32'h0, 1'b1);
    total++; if (q_rs1_val !== 32'hFFFF_80FF) begin bad++; $display("[TB] FAIL lh_data: got %0h expected ffff80ff", q_rs1_val); end
    tick();
    bus_ready = 1'b0;
  endtask

  task automatic test_store_wait();
    bus_ready = 1'b0;
    issue(INSN_SH, 32'h0000_2002, 32'h1234_ABCD, 1'b0);
    total++; if (bus_we !== 4'b1100) begin bad++; $display("[TB] FAIL sh_we: got %0h expected c", bus_we); end
    total++; if (bus_wdata[31:16] !== 16'hABCD) begin bad++; $display("[TB] FAIL sh_wdata: got %0h expected abcd", bus_wdata[31:16]); end
    total++; if (bus_addr !== 30'h800) begin bad++; $display("[TB] FAIL sh_addr: got %0h expected 800", bus_addr); end
    for (int i = 0; i < 3; i++) begin
      total++; if (fw_busy_mem !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("[TB] FAIL sh_busy_%0d: got busy=%0h valid=%0h expected 1/0", i, fw_busy_mem, q_valid); end
      if (i < 2) tick();
    end
    bus_ready = 1'b1;
    #1;
    total++; if (fw_busy_mem !== 1'b0 || q_valid !== 1'b1) begin bad++; $display("[TB] FAIL sh_done: got busy=%0h valid=%0h expected 0/1", fw_busy_mem, q_valid); end
    total++; if (bus_we !== 4'b1100 || fw_rd !== 1'b0) begin bad++; $display("[TB] FAIL sh_held: got we=%0h fw_rd=%0h expected c/0", bus_we, fw_rd); end
    tick();
    bus_ready = 1'b0;
    #1;
    total++; if (bus_we !== 4'b0000) begin bad++; $display("[TB] FAIL sh_idle: got %0h expected 0", bus_we); end
  endtask

  task automatic test_load_hold();
    int pulses = 0;
    bus_rdata = 32'hDEAD_BEEF; bus_ready = 1'b1;
    issue(INSN_LW, 32'h0000_4000, 32'h0, 1'b1);
    fw_stall_mem = 1'b1;
    #1;
    if (bus_re === 1'b1) pulses++;
    total++; if (q_rs1_val !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lw_data: got %0h expected deadbeef", q_rs1_val); end
    tick();
    bus_ready = 1'b0; bus_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus_re === 1'b1) pulses++;
      total++; if (q_rs1_val !== 32'hDEAD_BEEF || fw_rd !== 1'b1) begin bad++; $display("[TB] FAIL hold_data_%0d: got %0h fw_rd=%0h expected deadbeef/1", i, q_rs1_val, fw_rd); end
      if (i == 0) tick();
    end
    fw_stall_mem = 1'b0;
    tick();
    if (bus_re === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL hold_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_misaligned();
`ifdef BOA_MEM_MISALIGN_SPLIT_EN
    bus_ready = 1'b1; bus_rdata = 32'h3322_1100;
    issue(INSN_LW, 32'h0000_4002, 32'h0, 1'b1);
    total++; if (bus_re !== 1'b1 || bus_addr !== 30'h1000 || fw_busy_mem !== 1'b1) begin bad++; $display("[TB] FAIL split_first: got re=%0h addr=%0h busy=%0h expected 1/1000/1", bus_re, bus_addr, fw_busy_mem); end
    tick();
    bus_rdata = 32'h7766_5544;
    #1;
    total++; if (bus_addr !== 30'h1001) begin bad++; $display("[TB] FAIL split_addr: got %0h expected 1001", bus_addr); end
    total++; if (q_rs1_val !== 32'h5544_3322 || q_valid !== 1'b1) begin bad++; $display("[TB] FAIL split_data: got %0h valid=%0h expected 55443322/1", q_rs1_val, q_valid); end
    tick();
    bus_ready = 1'b0;
`else
    bus_ready = 1'b1;
    issue(INSN_LW, 32'h0000_4002, 32'h0, 1'b1);
    total++; if (bus_re !== 1'b0 || bus_we !== 4'b0000) begin bad++; $display("[TB] FAIL mis_bus: got re=%0h we=%0h expected 0/0", bus_re, bus_we); end
    total++; if (q_trap !== 1'b1 || q_cause !== 4'd4) begin bad++; $display("[TB] FAIL mis_trap: got %0h cause=%0d expected 1/4", q_trap, q_cause); end
    total++; if (q_valid !== 1'b1 || fw_rd !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid: got %0h fw_rd=%0h expected 1/0", q_valid, fw_rd); end
    tick();
    bus_ready = 1'b0;
`endif
  endtask

  task automatic test_fault_and_clear();
    bus_ready = 1'b1; bus_fault = 1'b1;
    issue(INSN_SW, 32'h0000_3000, 32'hCAFE_F00D, 1'b0);
    total++; if (bus_we !== 4'b1111) begin bad++; $display("[TB] FAIL sw_we: got %0h expected f", bus_we); end
    total++; if (q_trap !== 1'b1 || q_cause !== 4'd7) begin bad++; $display("[TB] FAIL sw_fault: got %0h cause=%0d expected 1/7", q_trap, q_cause); end
    tick();
    bus_ready = 1'b0; bus_fault = 1'b0;
    issue(INSN_LW, 32'h0000_5000, 32'h0, 1'b1);
    tick();
    clear = 1'b1;
    #1;
    total++; if (bus_re !== 1'b1 || q_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_wait: got re=%0h valid=%0h expected 1/0", bus_re, q_valid); end
    tick();
    bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    total++; if (bus_re !== 1'b1 || q_valid !== 1'b0 || q_trap !== 1'b0) begin bad++; $display("[TB] FAIL clr_ready: got re=%0h valid=%0h trap=%0h expected 1/0/0", bus_re, q_valid, q_trap); end
    tick();
    clear = 1'b0; bus_ready = 1'b0;
    #1;
    total++; if (bus_re !== 1'b0 || q_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_after: got re=%0h valid=%0h expected 0/0", bus_re, q_valid); end
  endtask

  task automatic test_passthrough();
    issue(INSN_ADD, 32'h0000_0055, 32'h0000_0077, 1'b1);
    total++; if (q_rs1_val !== 32'h55 || fw_rd !== 1'b1 || q_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_pass: got %0h fw_rd=%0h valid=%0h expected 55/1/1", q_rs1_val, fw_rd, q_valid); end
    total++; if (bus_re !== 1'b0 || bus_we !== 4'b0000 || q_pc !== 31'h800) begin bad++; $display("[TB] FAIL add_bus: got re=%0h we=%0h pc=%0h expected 0/0/800", bus_re, bus_we, q_pc); end
    d_valid = 1'b1; d_insn = INSN_LW; d_rs1_val = 32'h0000_4000; d_trap = 1'b1; d_cause = 4'd2;
    tick();
    d_valid = 1'b0; d_trap = 1'b0;
    #1;
    total++; if (q_trap !== 1'b1 || q_cause !== 4'd2 || bus_re !== 1'b0) begin bad++; $display("[TB] FAIL up_trap: got %0h cause=%0d re=%0h expected 1/2/0", q_trap, q_cause, bus_re); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    bus_ready = 1'b0;
    issue(INSN_LW, 32'h0000_6000, 32'h0, 1'b1);
    tick();
    total++; if (fw_busy_mem !== 1'b1 || bus_re !== 1'b1) begin bad++; $display("[TB] FAIL rst_wait: got busy=%0h re=%0h expected 1/1", fw_busy_mem, bus_re); end
    rst_n = 1'b0;
    tick();
    total++; if (bus_re !== 1'b0 || q_valid !== 1'b0 || fw_busy_mem !== 1'b0) begin bad++; $display("[TB] FAIL rst_abandon: got re=%0h valid=%0h busy=%0h expected 0/0/0", bus_re, q_valid, fw_busy_mem); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_load_hold();
    test_misaligned();
    test_fault_and_clear();
    test_passthrough();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
